// File: rtl/add_seq_ctrl.sv
// rtl/add_seq_ctrl.sv - byte-serial multi-precision add/subtract sequencer around one 8-bit ripple adder
module FA_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       co_bit_8
);
  logic [8:0] c;

  always_comb begin
    c      = '0;
    sum    = '0;
    c[0]   = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    co_bit_8 = c[8];
  end
endmodule

module add_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  op_sub,
  input  logic                  cin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [NBYTES-1:0][7:0]   a_reg;
  logic [NBYTES-1:0][7:0]   b_reg;
  logic [NBYTES-1:0][7:0]   res_reg;
  logic                     carry_reg;
  logic [IDXW-1:0]          idx;

  logic [7:0]               add_a;
  logic [7:0]               add_b;
  logic [7:0]               add_sum;
  logic                     add_co;

  // Adder inputs always come from registers, so nothing floats outside RUN.
  assign add_a    = a_reg[idx];
  assign add_b    = b_reg[idx];
  assign in_ready = (state == IDLE);
  assign result   = res_reg;

  FA_8_bit u_fa (
    .a        (add_a),
    .b        (add_b),
    .cin      (carry_reg),
    .sum      (add_sum),
    .co_bit_8 (add_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1, so the inversion and the +1 happen at capture.
            a_reg     <= op_a;
            b_reg     <= op_sub ? ~op_b : op_b;
            carry_reg <= op_sub ? 1'b1 : cin_in;
            idx       <= '0;
            res_reg   <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          res_reg[idx] <= add_sum;
          carry_reg    <= add_co;
          if (idx == LAST_IDX) begin
            cout      <= add_co;
            ovf       <= (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb/tb_add_seq_ctrl.sv - directed bench for add_seq_ctrl with NBYTES=4
module tb_add_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic        cin_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cout;
  logic        ovf;
  logic        busy;

  int total = 0;
  int bad   = 0;

  add_seq_ctrl #(.NBYTES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .cin_in    (cin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for out_valid; leaves the result in DONE.
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic ci);
    int n;
    @(negedge clk);
    op_a = a; op_b = b; op_sub = sub; cin_in = ci; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    chk({tag, "_inrdy"}, {31'b0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 32'd4);
  endtask

  task automatic finish_hs(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ovld_clr"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_inrdy_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic op_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic ci,
                          input logic [31:0] er, input logic ec, input logic eo);
    issue(tag, a, b, sub, ci);
    chk({tag, "_result"}, result, er);
    chk({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
    chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
    finish_hs(tag);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0;
    cin_in = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_inrdy", {31'b0, in_ready}, 32'd1);
    chk("rst_ovld", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_cout_ovf", {30'b0, cout, ovf}, 32'd0);

    op_check("add_chain", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
    op_check("add_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    op_check("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    op_check("add_cin",   32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0);
    op_check("sub_neg",   32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
    op_check("sub_ovf",   32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

    // Back-pressure in DONE while new operands are offered.
    issue("hold", 32'h00000010, 32'h00000020, 1'b0, 1'b0);
    op_a = 32'hDEADBEEF; op_b = 32'h12345678; op_sub = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("hold_result", result, 32'h00000030);
      chk("hold_flags", {29'b0, out_valid, cout, ovf}, 32'b100);
      chk("hold_inrdy", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    finish_hs("hold");
    chk("hold_after_hs", result, 32'h00000030);

    // Reset during the second RUN cycle.
    @(negedge clk);
    op_a = 32'h11111111; op_b = 32'h22222222; op_sub = 1'b0; cin_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovld", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_inrdy", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_no_ovld", seen, 32'd0);
    op_check("post_rst", 32'h01010101, 32'h01010101, 1'b0, 1'b0, 32'h02020202, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/add_seq_ctrl.md
# add_seq_ctrl

Byte-serial multi-precision add/subtract sequencer built around the existing 8-bit ripple adder (`FA_8_bit`, ports a, b, cin, sum, co_bit_8), instantiated once inside this block. It accepts two NBYTES-wide operands over a valid/ready handshake. It then steps the shared 8-bit adder through the operands one byte per cycle, least-significant byte first, chaining the carry through a register. The full-width result, carry-out and signed overflow are presented on an output valid/ready handshake. It sits between an operand source (register file or test harness) and any consumer needing wide arithmetic without a wide adder.

## Interface
Parameters:
- NBYTES, 4, operand width in bytes; legal range 1 to 16.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands and control valid.
- in_ready, output, 1, block can accept operands; high only in IDLE.
- op_a, input, 8*NBYTES, operand A.
- op_b, input, 8*NBYTES, operand B.
- op_sub, input, 1, 0 = A+B+cin_in; 1 = A-B (cin_in ignored).
- cin_in, input, 1, carry-in for add.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- result, output, 8*NBYTES, sum or difference.
- cout, output, 1, carry-out of MS byte; for sub, 1 = no borrow.
- ovf, output, 1, signed two's-complement overflow.
- busy, output, 1, high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture the following, then go to RUN:
  - a_reg = op_a;
  - b_reg = op_sub ? ~op_b : op_b;
  - carry_reg = op_sub ? 1 : cin_in;
  - idx = 0;
  - clear the result register.
- RUN: the adder is driven with a=a_reg byte idx, b=b_reg byte idx, cin=carry_reg.
  - Each cycle: result byte idx <= sum; carry_reg <= co_bit_8; idx <= idx+1.
  - When idx==NBYTES-1:
    - cout <= co_bit_8;
    - ovf <= (a_msb == b_msb_eff) && (sum[7] != a_msb), where b_msb_eff is the bit taken from b_reg (post-inversion);
    - go to DONE.
- DONE: out_valid=1; result, cout and ovf are held stable. On out_ready, go to IDLE.
- in_valid outside IDLE is ignored; operands are not sampled.
- idx width is clog2(NBYTES) with a minimum of 1. idx never exceeds NBYTES-1; no wrap is observable.
- NBYTES=1: RUN lasts exactly one cycle.
- The adder inputs are don't-care outside RUN, but are driven from registers (no X propagation).

## Timing
- Reset (async assert, sync-released by the surrounding system):
  - state=IDLE;
  - in_ready=1 (combinational from state);
  - out_valid=0, busy=0;
  - result=0, cout=0, ovf=0;
  - internal regs=0.
- Accept on edge k. RUN occupies cycles k+1 .. k+NBYTES. out_valid is high from the edge ending cycle k+NBYTES.
- Latency: accept edge to out_valid is NBYTES cycles.
- Minimum issue interval is NBYTES+2 cycles: accept, NBYTES RUN cycles, DONE for at least one cycle, back in IDLE.
- out_valid stays high until out_ready is sampled high. in_ready is 0 throughout.
- result/cout/ovf stay valid after the handshake until the next accept clears them.
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE with all outputs at reset values; the in-flight operation is discarded, with no partial out_valid.
- The critical path is one 8-bit ripple plus the mux select on idx; no multi-cycle paths.

## Test plan
(NBYTES=4)
- Reset, then check idle outputs: in_ready=1, out_valid=0, busy=0, result=0.
- Add 0x000000FF + 0x00000001, cin 0: after 4 cycles result=0x00000100, cout=0, ovf=0. Verifies byte carry chaining.
- Add 0xFFFFFFFF + 0x00000001, cin 0: result=0x00000000, cout=1, ovf=0. Add 0x7FFFFFFF + 0x00000001: result=0x80000000, ovf=1.
- Sub 5 - 7: result=0xFFFFFFFE, cout=0, ovf=0. Sub 0x80000000 - 1: result=0x7FFFFFFF, cout=1, ovf=1.
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands: result/cout/ovf stable, in_ready=0, new operands not captured. The handshake then completes and in_ready=1 the next cycle.
- Assert rst_n=0 during the 2nd RUN cycle: outputs go to reset values immediately. No out_valid follows, and a fresh add 0x01010101 + 0x01010101 yields 0x02020202.
